// File: rtl/flag_pkg.sv
// Shared definitions for the condition-flag file: default width, flag indices,
// the in-flight update record and the snapshot-stack pointer width.
package flag_pkg;

  localparam int NFLAGS_DEF = 3;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  // One in-flight update at the default flag width: per-bit write mask and value.
  typedef struct packed {
    logic [NFLAGS_DEF-1:0] mask;
    logic [NFLAGS_DEF-1:0] val;
  } flag_stage_t;

  // The pointer must be able to hold 0..depth inclusive.
  function automatic int sp_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/flag_stack.sv
// LIFO of flag snapshots for interrupt/call context, with full/empty status
// and a sticky error for push-when-full or pop-when-empty.
module flag_stack
  import flag_pkg::*;
#(
  parameter int NFLAGS = NFLAGS_DEF,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              push,
  input  logic              pop,
  input  logic [NFLAGS-1:0] push_data,
  output logic [NFLAGS-1:0] pop_data,
  output logic              restore,
  output logic              full,
  output logic              empty,
  output logic              err
);

  localparam int SPW = sp_width(DEPTH);

  logic [SPW-1:0]    sp;
  logic [SPW-1:0]    sp_top;
  // Sized to the full pointer range so any pointer value indexes it directly.
  logic [NFLAGS-1:0] mem [2**SPW];
  logic              do_push;
  logic              bad_op;

  assign full    = (sp == SPW'(DEPTH));
  assign empty   = (sp == '0);
  assign sp_top  = sp - 1'b1;
  assign do_push = en && push && !pop && !full;
  assign restore = en && pop && !push && !empty;
  assign bad_op  = en && ((push && !pop && full) || (pop && !push && empty));
  assign pop_data = mem[sp_top];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp  <= '0;
      err <= 1'b0;
    end else begin
      if (do_push) sp <= sp + 1'b1;
      else if (restore) sp <= sp_top;
      if (bad_op) err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[sp] <= push_data;
  end

endmodule

// File: rtl/flag_file.sv
// Parametrised condition-flag file: per-flag masked updates committed through a
// delay pipeline with stall/flush, plus a snapshot stack. Build option FLAG_FWD_EN
// enables forwarding of in-flight updates onto fwd_flag.
module flag_file
  import flag_pkg::*;
#(
  parameter int NFLAGS      = NFLAGS_DEF,
  parameter int PIPE_STAGES = 1,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [NFLAGS-1:0] upd_en,
  input  logic [NFLAGS-1:0] upd_val,
  input  logic              push,
  input  logic              pop,
  output logic [NFLAGS-1:0] flag,
  output logic [NFLAGS-1:0] fwd_flag,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              stack_err
);

  typedef struct packed {
    logic [NFLAGS-1:0] mask;
    logic [NFLAGS-1:0] val;
  } stage_t;

  logic              advance;
  logic [NFLAGS-1:0] cm_mask;
  logic [NFLAGS-1:0] cm_val;
  logic [NFLAGS-1:0] commit_flag;
  logic [NFLAGS-1:0] pop_data;
  logic              restore;
`ifdef FLAG_FWD_EN
  logic [NFLAGS-1:0] fwd_merge;
`endif

  assign advance = !stall && !flush;

  generate
    if (PIPE_STAGES == 0) begin : g_direct
      assign cm_mask = upd_en;
      assign cm_val  = upd_val;
`ifdef FLAG_FWD_EN
      assign fwd_merge = flag;
`endif
    end else begin : g_pipe
      stage_t stage_p [PIPE_STAGES];

      // Stage 0 captures the decoder's update; the last stage feeds the commit.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < PIPE_STAGES; k++) stage_p[k] <= '0;
        end else if (flush) begin
          for (int k = 0; k < PIPE_STAGES; k++) stage_p[k].mask <= '0;
        end else if (!stall) begin
          stage_p[0] <= '{mask: upd_en, val: upd_val};
          for (int k = 1; k < PIPE_STAGES; k++) stage_p[k] <= stage_p[k-1];
        end
      end

      assign cm_mask = stage_p[PIPE_STAGES-1].mask;
      assign cm_val  = stage_p[PIPE_STAGES-1].val;

`ifdef FLAG_FWD_EN
      // Oldest stage first so the youngest pending write wins per bit.
      always_comb begin
        fwd_merge = flag;
        for (int k = PIPE_STAGES - 1; k >= 0; k--)
          fwd_merge = (fwd_merge & ~stage_p[k].mask) | (stage_p[k].val & stage_p[k].mask);
      end
`endif
    end
  endgenerate

  assign commit_flag = (flag & ~cm_mask) | (cm_val & cm_mask);

  // Commit boundary: a stack restore overrides the committing update on all bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) flag <= '0;
    else if (advance) flag <= restore ? pop_data : commit_flag;
  end

  flag_stack #(
    .NFLAGS (NFLAGS),
    .DEPTH  (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .en        (advance),
    .push      (push),
    .pop       (pop),
    .push_data (commit_flag),
    .pop_data  (pop_data),
    .restore   (restore),
    .full      (stack_full),
    .empty     (stack_empty),
    .err       (stack_err)
  );

`ifdef FLAG_FWD_EN
  assign fwd_flag = fwd_merge;
`else
  assign fwd_flag = flag;
`endif

endmodule

// File: doc/flag_file.md
Name: flag_file

Overview:
- Parametrised successor to the 3-bit Z/V/N flag register.
- Holds NFLAGS condition flags, each with its own write enable.
- Commits updates through PIPE_STAGES delay stages, with stall and flush control.
- Provides a save/restore stack of STACK_DEPTH entries for interrupt/call context.
- Sits between the ALU/decoder (which supply the per-flag mask) and branch-condition logic.

Parameters:
- NFLAGS, 3: number of flag bits. Index 2=Z, 1=V, 0=N when 3.
- PIPE_STAGES, 1: update-to-commit delay in cycles. Legal range 0..3.
- STACK_DEPTH, 4: number of snapshot stack entries. Legal range 1..16.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset.
- stall  in  1  freeze pipeline, commit and stack.
- flush  in  1  kill all in-flight (uncommitted) updates.
- upd_en  in  NFLAGS  per-flag write mask for the current instruction.
- upd_val  in  NFLAGS  new flag values, qualified by upd_en.
- push  in  1  snapshot flags onto the stack.
- pop  in  1  restore flags from the stack top.
- flag  out  NFLAGS  architectural (committed) flags.
- fwd_flag  out  NFLAGS  flags including pending in-flight updates.
- stack_full  out  1  stack pointer == STACK_DEPTH.
- stack_empty  out  1  stack pointer == 0.
- stack_err  out  1  sticky: push-when-full or pop-when-empty occurred.

Behaviour:
- Reset: one clock; rst is asynchronous, active-high. While rst is asserted, and immediately on assertion:
  - flag=0, all stage masks/values=0, stack pointer=0, stack_err=0.
  - Hence stack_empty=1, stack_full=0, fwd_flag=0.
  - Reset mid-operation discards pending updates and stack contents.
- Pipeline, PIPE_STAGES>=1:
  - Stage k holds {mask,val}.
  - On an edge with !stall && !flush: stage0 <= {upd_en,upd_val}; stage k <= stage k-1; last stage commits.
- Pipeline, PIPE_STAGES=0: upd_en/upd_val commit directly on the edge when !stall && !flush.
- Commit: for each i, flag[i] <= mask[i] ? val[i] : flag[i]. Bits with mask 0 always hold.
- Latency: an update presented at edge n is visible on flag after edge n+PIPE_STAGES. At PIPE_STAGES=0 it is visible after edge n.
- stall=1 (and flush=0): all stages, flag, stack pointer and stack contents hold. Inputs are ignored.
- flush=1: highest priority after rst, overrides stall.
  - All stage masks clear to 0.
  - The committing stage does not commit.
  - Current inputs are not captured.
  - flag and stack are unchanged.
- fwd_flag (combinational):
  - Start from flag, apply stage masks oldest to youngest; youngest wins per bit.
  - Current-cycle upd_en/upd_val are not included.
  - Equals flag when all masks are 0 or PIPE_STAGES=0.
- Stack ops apply only when !stall && !flush:
  - push, not full: entry[sp] <= next-state flag (post-commit of this edge); sp+1.
  - pop, not empty: flag <= entry[sp-1]; sp-1. The restore overrides that edge's commit for all bits. Pipeline stages still shift.
  - push && pop together: stack unchanged, normal commit.
  - push when full / pop when empty: no state change except stack_err <= 1.
- stack_err clears only on rst.

Optional Feature:
- Macro FLAG_FWD_EN.
  - Defined: fwd_flag is the forwarded merge described above.
  - Undefined: fwd_flag is tied to flag and the merge logic is not built.
- All other behaviour is identical in both builds.

Decomposition:
- Package flag_pkg:
  - NFLAGS default.
  - Flag index constants FLAG_Z=2, FLAG_V=1, FLAG_N=0.
  - Stage record typedef {mask,val}.
  - Stack pointer width function (clog2(STACK_DEPTH+1)).
- Sub-module flag_stack:
  - Parametrised LIFO with push/pop, full/empty and error sticky.
  - flag_file instantiates it; pipeline and forwarding stay in the top.

Test Plan:
- PIPE_STAGES=1: upd_en=111, upd_val=101 at edge 0 → fwd_flag=101 after edge 0; flag=101 after edge 1.
- Partial mask: flag=111, then upd_en=010, upd_val=000 → flag=101 after commit. Bits 2 and 0 hold.
- Flush: update 011/011 in flight, flush=1 on the commit cycle → flag stays 000; fwd_flag returns to 000.
- Stall: 2-cycle stall with a pending update → flag unchanged during the stall; commit occurs on the first non-stall edge.
- Stack, STACK_DEPTH=2:
  - flag=110: push, push, push → stack_full=1, stack_err=1.
  - Then update flag to 001, then pop → flag=110, stack_full=0.
- Async reset: assert rst mid-cycle with stages loaded and sp=1 → flag=000, stack_empty=1, stack_err=0 before the next edge.
